// File: rtl/ahblite_interconnect_arbiter.sv
// rtl/ahblite_interconnect_arbiter.sv - multi-master AHB-Lite address-phase arbiter
//
// Ports:
//   HCLK, HRESETn        bus clock, synchronous active-low reset
//   req_i                bus request per master
//   prio_i               priority per master, PRIO_W bits each, larger wins
//   htrans_i, hburst_i   HTRANS (2b) / HBURST (3b) per master
//   hmastlock_i          HMASTLOCK per master
//   hready_i             HREADY from slave mux
//   grant_o, addr_sel_o  one-hot grant / index of address-phase owner
//   data_sel_o           index of data-phase owner
//   burst_active_o       owner is inside a fixed-length burst
module ahblite_interconnect_arbiter #(
   parameter int NUM_MST     = 4,
   parameter int PRIO_W      = 2,
   parameter int DEFAULT_MST = 0,
   parameter int SEL_W       = $clog2(NUM_MST)
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [NUM_MST-1:0]        req_i,
   input  logic [NUM_MST*PRIO_W-1:0] prio_i,
   input  logic [NUM_MST*2-1:0]      htrans_i,
   input  logic [NUM_MST*3-1:0]      hburst_i,
   input  logic [NUM_MST-1:0]        hmastlock_i,
   input  logic                      hready_i,
   output logic [NUM_MST-1:0]        grant_o,
   output logic [SEL_W-1:0]          addr_sel_o,
   output logic [SEL_W-1:0]          data_sel_o,
   output logic                      burst_active_o
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ    = 2'b11;

   localparam logic [2:0] BURST_SINGLE = 3'd0;
   localparam logic [2:0] BURST_WRAP4  = 3'd2;
   localparam logic [2:0] BURST_INCR4  = 3'd3;
   localparam logic [2:0] BURST_WRAP8  = 3'd4;
   localparam logic [2:0] BURST_INCR8  = 3'd5;
   localparam logic [2:0] BURST_WRAP16 = 3'd6;
   localparam logic [2:0] BURST_INCR16 = 3'd7;

   logic [SEL_W-1:0]  owner;
   logic [SEL_W-1:0]  data_sel;
   logic [3:0]        beat_cnt;

   logic [1:0]        own_trans;
   logic [2:0]        own_burst;
   logic              own_lock;
   logic [SEL_W-1:0]  winner;
   logic              rearb;

   // Only the current owner's transfer controls matter for arbitration.
   always_comb begin
      own_trans = TRANS_IDLE;
      own_burst = BURST_SINGLE;
      own_lock  = 1'b0;
      for (int m = 0; m < NUM_MST; m++) begin
         if (owner == SEL_W'(m)) begin
            own_trans = htrans_i[m*2 +: 2];
            own_burst = hburst_i[m*3 +: 3];
            own_lock  = hmastlock_i[m];
         end
      end
   end

   // Scan starts just after the owner so that equal priorities rotate;
   // a strictly greater priority is needed to displace an earlier candidate.
   always_comb begin
      logic [PRIO_W-1:0] best_prio;
      logic              found;
      int                idx;
      best_prio = '0;
      found     = 1'b0;
      idx       = 0;
      winner    = SEL_W'(DEFAULT_MST);
      for (int k = 1; k <= NUM_MST; k++) begin
         idx = (int'(owner) + k) % NUM_MST;
         if (req_i[idx] && (!found || prio_i[idx*PRIO_W +: PRIO_W] > best_prio)) begin
            found     = 1'b1;
            best_prio = prio_i[idx*PRIO_W +: PRIO_W];
            winner    = SEL_W'(idx);
         end
      end
   end

   // A SEQ seen with beat_cnt==1 is the final beat of a fixed burst.
   // INCR bursts never load beat_cnt, so they only release on IDLE.
   assign rearb = hready_i && !own_lock &&
                  ((own_trans == TRANS_IDLE) ||
                   (own_trans == TRANS_NONSEQ && own_burst == BURST_SINGLE) ||
                   (own_trans == TRANS_SEQ && beat_cnt == 4'd1));

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         owner    <= SEL_W'(DEFAULT_MST);
         data_sel <= SEL_W'(DEFAULT_MST);
         beat_cnt <= '0;
      end else if (hready_i) begin
         data_sel <= owner;
         if (rearb) begin
            owner    <= winner;
            beat_cnt <= '0;
         end else if (own_trans == TRANS_NONSEQ) begin
            case (own_burst)
               BURST_WRAP4,  BURST_INCR4:  beat_cnt <= 4'd3;
               BURST_WRAP8,  BURST_INCR8:  beat_cnt <= 4'd7;
               BURST_WRAP16, BURST_INCR16: beat_cnt <= 4'd15;
               default: ;
            endcase
         end else if (own_trans == TRANS_SEQ && beat_cnt != 4'd0) begin
            beat_cnt <= beat_cnt - 4'd1;
         end
      end
   end

   assign grant_o        = NUM_MST'(1) << owner;
   assign addr_sel_o     = owner;
   assign data_sel_o     = data_sel;
   assign burst_active_o = (beat_cnt != 4'd0);

endmodule
